uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_if.sv | 32 +++
 rtl/uart_tx_sched.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Handshake and transmitter-side signals of the UART transmit scheduler.
// The scheduler uses the slave view; the requesters and the transmitter use the master view.
interface uart_tx_sched_if #(
  parameter int WIDTH = 8
);

  logic                 reg_req;
  logic [WIDTH-1:0]     reg_data;
  logic                 reg_ack;

  logic                 alu_req;
  logic [2*WIDTH-1:0]   alu_data;
  logic                 alu_ack;

  logic                 tx_busy;
  logic [WIDTH-1:0]     tx_p_data;
  logic                 tx_data_valid;

  logic                 sched_idle;
  logic [7:0]           frame_cnt;

  modport slave (
    input  reg_req, reg_data, alu_req, alu_data, tx_busy,
    output reg_ack, alu_ack, tx_p_data, tx_data_valid, sched_idle, frame_cnt
  );

  modport master (
    output reg_req, reg_data, alu_req, alu_data, tx_busy,
    input  reg_ack, alu_ack, tx_p_data, tx_data_valid, sched_idle, frame_cnt
  );

endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter from two requesters:
// a register-read port (one byte per transaction) and an ALU port (one
// 2*WIDTH result sent as two bytes, low byte first). Each byte is strobed
// once, then the scheduler waits for the transmitter's busy flag to rise
// and fall; if busy never rises within BUSY_TO cycles the byte is re-issued.
module uart_tx_sched #(
  parameter int WIDTH   = 8,
  parameter int BUSY_TO = 4
) (
  input  logic           clk,
  input  logic           rstn,
  uart_tx_sched_if.slave bus
);

  // Timeout counter only needs to reach BUSY_TO-1.
  localparam int              TO_W    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // Control state
  logic             last_alu_q;   // 1: the ALU port received the most recent grant
  logic [1:0]       byte_cnt_q;   // bytes of the current transaction not yet completed
  logic [TO_W-1:0]  to_cnt_q;     // consecutive WAIT_HI cycles without busy
  logic [7:0]       frame_cnt_q;
  logic             reg_ack_q;
  logic             alu_ack_q;
  logic [WIDTH-1:0] tx_byte_q;    // byte currently offered to the transmitter

  // Data captured from the ALU port, sent as the second byte
  logic [WIDTH-1:0] hi_byte_q;

  // Per-cycle decisions produced by the next-state logic
  logic             grant_reg;
  logic             grant_alu;
  logic             load_next;
  logic             frame_done;
  logic             to_clr;
  logic             to_inc;

  // Next-state and decision logic; arbitration only happens in IDLE with the transmitter free.
  always_comb begin
    state_d    = state_q;
    grant_reg  = 1'b0;
    grant_alu  = 1'b0;
    load_next  = 1'b0;
    frame_done = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.tx_busy) begin
          // On a tie the port that did not win last time is served.
          if (bus.reg_req && (!bus.alu_req || last_alu_q)) begin
            grant_reg = 1'b1;
            state_d   = SEND;
          end else if (bus.alu_req) begin
            grant_alu = 1'b1;
            state_d   = SEND;
          end
        end
      end
      SEND: begin
        to_clr  = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (to_cnt_q == TO_LAST) begin
          // Transmitter never picked the byte up: strobe it again.
          state_d = SEND;
        end else begin
          to_inc = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (byte_cnt_q > 2'd1) begin
            load_next = 1'b1;
            state_d   = SEND;
          end else begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers and the outgoing byte; a reset drops any captured transaction.
  always_ff @(posedge clk) begin
    if (rstn) begin
      last_alu_q  <= 1'b1;
      byte_cnt_q  <= 2'd0;
      to_cnt_q    <= '0;
      frame_cnt_q <= 8'd0;
      reg_ack_q   <= 1'b0;
      alu_ack_q   <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      reg_ack_q <= grant_reg;
      alu_ack_q <= grant_alu;

      if (grant_reg) begin
        last_alu_q <= 1'b0;
        byte_cnt_q <= 2'd1;
      end else if (grant_alu) begin
        last_alu_q <= 1'b1;
        byte_cnt_q <= 2'd2;
      end else if (load_next || frame_done) begin
        byte_cnt_q <= byte_cnt_q - 2'd1;
      end

      if (to_clr) begin
        to_cnt_q <= '0;
      end else if (to_inc) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end

      if (grant_reg) begin
        tx_byte_q <= bus.reg_data;
      end else if (grant_alu) begin
        tx_byte_q <= bus.alu_data[WIDTH-1:0];
      end else if (load_next) begin
        tx_byte_q <= hi_byte_q;
      end
    end
  end

  // Upper ALU byte is pure data and is only meaningful after an ALU grant.
  always_ff @(posedge clk) begin
    if (grant_alu) begin
      hi_byte_q <= bus.alu_data[2*WIDTH-1:WIDTH];
    end
  end

  assign bus.reg_ack       = reg_ack_q;
  assign bus.alu_ack       = alu_ack_q;
  assign bus.tx_p_data     = tx_byte_q;
  assign bus.tx_data_valid = (state_q == SEND);
  assign bus.sched_idle    = (state_q == IDLE);
  assign bus.frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level model built on a byte queue.
module tb_uart_tx_sched;

  localparam int W  = 8;
  localparam int TO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.WIDTH(W)) bus ();

  uart_tx_sched #(.WIDTH(W), .BUSY_TO(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_q holds the bytes of the transaction in flight (front = byte on the wire).
  // m_quiet >= 0: waiting for busy to rise, counting quiet cycles; -1: waiting for busy to fall.
  logic [W-1:0] m_q[$];
  bit           m_strobe   = 1'b0;
  bit           m_reg_ack  = 1'b0;
  bit           m_alu_ack  = 1'b0;
  bit           m_last_alu = 1'b1;
  int           m_quiet    = 0;
  int           m_frames   = 0;
  logic [W-1:0] m_cur      = '0;

  always @(posedge clk) begin
    m_reg_ack = 1'b0;
    m_alu_ack = 1'b0;
    if (rstn) begin
      m_q.delete();
      m_strobe   = 1'b0;
      m_quiet    = 0;
      m_last_alu = 1'b1;
      m_frames   = 0;
      m_cur      = '0;
    end else if (m_q.size() == 0) begin
      if (!bus.tx_busy && (bus.reg_req || bus.alu_req)) begin
        if (bus.reg_req && (!bus.alu_req || m_last_alu)) begin
          m_q.push_back(bus.reg_data);
          m_reg_ack  = 1'b1;
          m_last_alu = 1'b0;
        end else begin
          m_q.push_back(bus.alu_data[W-1:0]);
          m_q.push_back(bus.alu_data[2*W-1:W]);
          m_alu_ack  = 1'b1;
          m_last_alu = 1'b1;
        end
        m_cur    = m_q[0];
        m_strobe = 1'b1;
      end
    end else if (m_strobe) begin
      m_strobe = 1'b0;
      m_quiet  = 0;
    end else if (m_quiet >= 0) begin
      if (bus.tx_busy) m_quiet = -1;
      else if (m_quiet + 1 == TO) m_strobe = 1'b1;
      else m_quiet++;
    end else if (!bus.tx_busy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_frames++;
      end else begin
        m_cur    = m_q[0];
        m_strobe = 1'b1;
      end
    end
  end

  // ---------------- compare process + strobe log ----------------
  bit           chk_en = 1'b0;
  int           cyc_n  = 0;
  logic [W-1:0] seen[$];
  int           strobe_t[$];

  always @(negedge clk) begin
    cyc_n++;
    if (chk_en) begin
      chk("tx_data_valid", int'(bus.tx_data_valid), int'(m_strobe));
      chk("reg_ack",       int'(bus.reg_ack),       int'(m_reg_ack));
      chk("alu_ack",       int'(bus.alu_ack),       int'(m_alu_ack));
      chk("tx_p_data",     int'(bus.tx_p_data),     int'(m_cur));
      chk("sched_idle",    int'(bus.sched_idle),    (m_q.size() == 0) ? 1 : 0);
      chk("frame_cnt",     int'(bus.frame_cnt),     m_frames & 255);
    end
    if (bus.tx_data_valid) begin
      seen.push_back(bus.tx_p_data);
      strobe_t.push_back(cyc_n);
    end
  end

  // ---------------- UART transmitter model ----------------
  // Auto mode: busy rises rise_dly cycles after a strobe and stays high hold_len cycles.
  bit uart_auto = 1'b0;
  bit busy_man  = 1'b0;
  bit armed     = 1'b0;
  int t_since   = 0;
  int rise_dly  = 1;
  int hold_len  = 1;
  int fix_rise  = 0;
  int fix_hold  = 0;

  always @(negedge clk) begin
    if (bus.tx_data_valid) begin
      armed    = 1'b1;
      t_since  = 0;
      rise_dly = (fix_rise > 0) ? fix_rise : int'($urandom_range(1, 6));
      hold_len = (fix_hold > 0) ? fix_hold : int'($urandom_range(1, 12));
    end else if (armed && t_since < 1000) begin
      t_since++;
    end
    bus.tx_busy = uart_auto ? (armed && t_since >= rise_dly && t_since < rise_dly + hold_len)
                            : busy_man;
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input bit alu, input int budget, output int lat);
    lat = 0;
    while (((alu ? bus.alu_ack : bus.reg_ack) == 1'b0) && lat < budget) begin
      cyc(1);
      lat++;
    end
    chk(alu ? "alu_ack_seen" : "reg_ack_seen", alu ? int'(bus.alu_ack) : int'(bus.reg_ack), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!bus.sched_idle && k < budget) begin
      cyc(1);
      k++;
    end
    chk("idle_reached", int'(bus.sched_idle), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int ra;
    int order[$];
    int n;

    bus.reg_req  = 1'b0;
    bus.alu_req  = 1'b0;
    bus.reg_data = '0;
    bus.alu_data = '0;
    rstn = 1'b1;
    cyc(3);

    // Reset values
    chk("rst_valid",     int'(bus.tx_data_valid), 0);
    chk("rst_reg_ack",   int'(bus.reg_ack),       0);
    chk("rst_alu_ack",   int'(bus.alu_ack),       0);
    chk("rst_tx_p_data", int'(bus.tx_p_data),     0);
    chk("rst_frame_cnt", int'(bus.frame_cnt),     0);
    chk("rst_idle",      int'(bus.sched_idle),    1);
    rstn   = 1'b0;
    chk_en = 1'b1;

    // Single register byte, busy 1 cycle after strobe for 11 cycles
    uart_auto = 1'b1; fix_rise = 1; fix_hold = 11;
    seen.delete(); strobe_t.delete();
    bus.reg_data = 8'hA5; bus.reg_req = 1'b1;
    wait_ack(1'b0, 20, lat);
    chk("reg_ack_latency", lat, 1);
    chk("reg_strobe_with_ack", int'(bus.tx_data_valid), 1);
    bus.reg_req = 1'b0;
    wait_idle(100);
    chk("t1_strobes", seen.size(), 1);
    chk("t1_byte", (seen.size() > 0) ? int'(seen[0]) : -1, 'hA5);
    chk("t1_frame_cnt", int'(bus.frame_cnt), 1);
    chk("t1_model_frames", m_frames, 1);
    chk("t1_model_byte", int'(m_cur), 'hA5);

    // Single ALU result: low byte, then high byte once busy falls
    seen.delete(); strobe_t.delete();
    bus.alu_data = 16'h1234; bus.alu_req = 1'b1;
    wait_ack(1'b1, 20, lat);
    chk("alu_ack_latency", lat, 1);
    bus.alu_req = 1'b0;
    wait_idle(200);
    chk("t2_strobes", seen.size(), 2);
    chk("t2_byte0", (seen.size() > 0) ? int'(seen[0]) : -1, 'h34);
    chk("t2_byte1", (seen.size() > 1) ? int'(seen[1]) : -1, 'h12);
    chk("t2_gap", (strobe_t.size() > 1) ? strobe_t[1] - strobe_t[0] : -1, 13);
    chk("t2_frame_cnt", int'(bus.frame_cnt), 2);
    chk("t2_model_frames", m_frames, 2);

    // Both requesters held high: REG, ALU, REG
    bus.reg_data = 8'h3C; bus.alu_data = 16'hBEEF;
    bus.reg_req = 1'b1; bus.alu_req = 1'b1;
    n = 0;
    while (order.size() < 3 && n < 300) begin
      cyc(1);
      n++;
      if (bus.reg_ack) order.push_back(1);
      if (bus.alu_ack) order.push_back(2);
    end
    bus.reg_req = 1'b0; bus.alu_req = 1'b0;
    chk("tie_grants", order.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("tie_order", (order.size() > i) ? order[i] : 0, (i == 1) ? 2 : 1);
    wait_idle(300);
    chk("t3_frame_cnt", int'(bus.frame_cnt), 5);

    // Busy never rises: same byte re-strobed every TO+1 cycles, single ack
    uart_auto = 1'b0; busy_man = 1'b0;
    seen.delete(); strobe_t.delete();
    bus.reg_data = 8'h5A; bus.reg_req = 1'b1;
    wait_ack(1'b0, 20, lat);
    bus.reg_req = 1'b0;
    ra = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(1);
      if (bus.reg_ack) ra++;
    end
    chk("no_reack", ra, 0);
    chk("reissue_count", strobe_t.size(), 5);
    for (int i = 1; i < strobe_t.size(); i++) begin
      chk("reissue_period", strobe_t[i] - strobe_t[i-1], TO + 1);
      chk("reissue_byte", int'(seen[i]), 'h5A);
    end
    busy_man = 1'b1;
    cyc(3);
    busy_man = 1'b0;
    wait_idle(50);
    chk("t4_frame_cnt", int'(bus.frame_cnt), 6);

    // Request while busy in IDLE: ack only after busy falls
    busy_man = 1'b1;
    cyc(2);
    bus.alu_data = 16'($urandom); bus.alu_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("busy_hold_ack", int'(bus.alu_ack), 0);
    end
    busy_man = 1'b0;
    wait_ack(1'b1, 10, lat);
    chk("busy_fall_latency", lat, 1);
    uart_auto = 1'b1;
    bus.alu_req = 1'b0;
    wait_idle(200);
    chk("t5_frame_cnt", int'(bus.frame_cnt), 7);

    // Reset during WAIT_LO of the first ALU byte
    bus.alu_data = 16'hCAFE; bus.alu_req = 1'b1;
    wait_ack(1'b1, 20, lat);
    bus.alu_req = 1'b0;
    cyc(4);
    rstn = 1'b1;
    cyc(1);
    rstn = 1'b0;
    chk("mid_rst_valid",     int'(bus.tx_data_valid), 0);
    chk("mid_rst_reg_ack",   int'(bus.reg_ack),       0);
    chk("mid_rst_alu_ack",   int'(bus.alu_ack),       0);
    chk("mid_rst_tx_p_data", int'(bus.tx_p_data),     0);
    chk("mid_rst_frame_cnt", int'(bus.frame_cnt),     0);
    chk("mid_rst_idle",      int'(bus.sched_idle),    1);
    chk("mid_rst_model",     m_frames,                0);
    seen.delete();
    cyc(30);
    chk("no_resume", seen.size(), 0);

    // Randomized traffic: random UART timing, withdrawals and occasional resets
    fix_rise = 0; fix_hold = 0; uart_auto = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (bus.reg_ack) bus.reg_req = 1'b0;
      else if (!bus.reg_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.reg_req  = 1'b1;
          bus.reg_data = 8'($urandom);
        end
      end else if ($urandom_range(0, 29) == 0) bus.reg_req = 1'b0;

      if (bus.alu_ack) bus.alu_req = 1'b0;
      else if (!bus.alu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.alu_req  = 1'b1;
          bus.alu_data = 16'($urandom);
        end
      end else if ($urandom_range(0, 29) == 0) bus.alu_req = 1'b0;

      rstn = ($urandom_range(0, 399) == 0);
    end
    bus.reg_req = 1'b0; bus.alu_req = 1'b0; rstn = 1'b0;
    wait_idle(500);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
